// File: rtl/mips_writeback.sv
// mips_writeback: register-file write port arbiter with a buffered memory-result FIFO.
// Optional macro WB_BYPASS_EN builds the pend_data forwarding mux.
module mips_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    input  logic [4:0]  pend_reg,
    output logic        pend_hit,
    output logic [31:0] pend_data,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]       q_reg  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit_vec;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;
    logic             squash;

    assign mem_ready = count < FULL;
    assign squash    = alu_valid && alu_reg != 5'd0;
    assign push      = mem_valid && mem_ready && mem_reg != 5'd0;
    assign pop       = !alu_valid && count != '0;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = live[i] && q_reg[i] == pend_reg;
        end
    end

    assign pend_hit = pend_reg != 5'd0 &&
                      (|hit_vec || (RegWrite && WriteReg == pend_reg));

`ifdef WB_BYPASS_EN
    logic [AW-1:0] idx;

    // Scan oldest to youngest so the youngest live match wins.
    always_comb begin
        pend_data = (RegWrite && WriteReg == pend_reg) ? WriteData : '0;
        idx = wr_ptr;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - AW'(k);
            if (hit_vec[idx]) begin
                pend_data = q_data[idx];
            end
        end
    end
`else
    assign pend_data = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            overflow  <= 1'b0;
            count     <= '0;
            live      <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            if (alu_valid) begin
                RegWrite  <= squash;
                WriteReg  <= alu_reg;
                WriteData <= alu_data;
            end else if (pop) begin
                RegWrite  <= live[rd_ptr];
                WriteReg  <= q_reg[rd_ptr];
                WriteData <= q_data[rd_ptr];
            end else begin
                RegWrite  <= 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && q_reg[i] == alu_reg) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + AW'(1);
            end
            // A same-cycle ALU write to the same register kills the new entry.
            if (push) begin
                live[wr_ptr] <= !(squash && mem_reg == alu_reg);
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            if (mem_valid && !mem_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_reg[wr_ptr]  <= mem_reg;
            q_data[wr_ptr] <= mem_data;
        end
    end

endmodule

// File: tb/tb_mips_writeback.sv
// tb_mips_writeback: directed scenarios plus random traffic against a queue model.
// Honours WB_BYPASS_EN the same way as the design.
module tb_mips_writeback;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_reg = '0;
    logic [31:0] mem_data = '0;
    logic [4:0]  pend_reg = '0;
    logic        mem_ready;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        pend_hit;
    logic [31:0] pend_data;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        q[$];
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    bit          m_ovf;

    mips_writeback #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .pend_reg(pend_reg), .pend_hit(pend_hit), .pend_data(pend_data),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Reference: the FIFO is an ordered queue of results, oldest first.
    task automatic model_step();
        bit   rdy;
        bit   sq;
        ent_t h;
        if (reset) begin
            q.delete();
            m_rw = 0; m_wr = '0; m_wd = '0; m_ovf = 0;
            return;
        end
        rdy = q.size() < DEPTH;
        sq  = alu_valid && alu_reg != 0;
        if (alu_valid) begin
            m_rw = sq; m_wr = alu_reg; m_wd = alu_data;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            m_rw = h.live; m_wr = h.r; m_wd = h.d;
        end else begin
            m_rw = 0;
        end
        if (sq) begin
            foreach (q[i]) if (q[i].r == alu_reg) q[i].live = 0;
        end
        if (mem_valid && !rdy) m_ovf = 1;
        if (mem_valid && rdy && mem_reg != 0) begin
            h.r = mem_reg; h.d = mem_data;
            h.live = !(sq && mem_reg == alu_reg);
            q.push_back(h);
        end
    endtask

    function automatic bit exp_hit();
        if (pend_reg == 0) return 0;
        foreach (q[i]) if (q[i].live && q[i].r == pend_reg) return 1;
        return m_rw && m_wr == pend_reg;
    endfunction

    function automatic logic [31:0] exp_pdata();
`ifdef WB_BYPASS_EN
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].live && q[i].r == pend_reg) return q[i].d;
        if (m_rw && m_wr == pend_reg) return m_wd;
`endif
        return '0;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #2;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0;
        alu_reg = '0; mem_reg = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h55;
        mem_valid = 1; mem_reg = 5'd3; mem_data = 32'h66;
        pend_reg = 5'd3;
        tick(); tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL rst_rw: got %0b want 0", RegWrite); else passed++;
        total++; if (WriteReg !== 5'd0) $display("FAIL rst_wr: got %0d want 0", WriteReg); else passed++;
        total++; if (WriteData !== 32'd0) $display("FAIL rst_wd: got %0h want 0", WriteData); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %0b want 0", overflow); else passed++;
        total++; if (mem_ready !== 1'b1) $display("FAIL rst_rdy: got %0b want 1", mem_ready); else passed++;
        total++; if (pend_hit !== 1'b0) $display("FAIL rst_hit: got %0b want 0", pend_hit); else passed++;
        reset = 0;
        idle();
    endtask

    task automatic test_alu();
        do_reset();
        alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h11;
        tick();
        total++; if (RegWrite !== 1'b1) $display("FAIL alu_rw: got %0b want 1", RegWrite); else passed++;
        total++; if (WriteReg !== 5'd3) $display("FAIL alu_wr: got %0d want 3", WriteReg); else passed++;
        total++; if (WriteData !== 32'h11) $display("FAIL alu_wd: got %0h want 11", WriteData); else passed++;
        idle();
        tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL alu_rw_off: got %0b want 0", RegWrite); else passed++;
    endtask

    task automatic test_mem_order();
        do_reset();
        mem_valid = 1; mem_reg = 5'd9; mem_data = 32'h99;
        tick();
        idle();
        total++; if (RegWrite !== 1'b0) $display("FAIL lat_push: got %0b want 0", RegWrite); else passed++;
        tick();
        total++; if (RegWrite !== 1'b1 || WriteReg !== 5'd9) $display("FAIL lat_pop: got rw=%0b reg=%0d want 1/9", RegWrite, WriteReg); else passed++;
        tick();
        // Stall pops with a reg-0 ALU op while four results queue up.
        alu_valid = 1; alu_reg = 5'd0;
        for (int i = 1; i <= 4; i++) begin
            mem_valid = 1; mem_reg = 5'(i); mem_data = 32'hA0 + i;
            tick();
            total++; if (RegWrite !== 1'b0) $display("FAIL fill_rw%0d: got %0b want 0", i, RegWrite); else passed++;
        end
        total++; if (mem_ready !== 1'b0) $display("FAIL fill_rdy: got %0b want 0", mem_ready); else passed++;
        idle();
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (RegWrite !== 1'b1 || WriteReg !== 5'(i) || WriteData !== 32'hA0 + i)
                $display("FAIL order%0d: got rw=%0b reg=%0d data=%0h want 1/%0d/%0h",
                         i, RegWrite, WriteReg, WriteData, i, 32'hA0 + i);
            else passed++;
        end
        tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL drain_end: got %0b want 0", RegWrite); else passed++;
        total++; if (mem_ready !== 1'b1) $display("FAIL drain_rdy: got %0b want 1", mem_ready); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        alu_valid = 1; alu_reg = 5'd0;
        for (int i = 1; i <= 4; i++) begin
            mem_valid = 1; mem_reg = 5'(i); mem_data = 32'hB0 + i;
            tick();
        end
        alu_reg = 5'd10; mem_reg = 5'd6;
        for (int i = 0; i < 6; i++) begin
            alu_data = $urandom; mem_data = $urandom;
            tick();
            total++;
            if (mem_ready !== 1'b0 || RegWrite !== 1'b1 || WriteReg !== 5'd10 || overflow !== 1'b1)
                $display("FAIL ovf_cyc%0d: got rdy=%0b rw=%0b reg=%0d ovf=%0b want 0/1/10/1",
                         i, mem_ready, RegWrite, WriteReg, overflow);
            else passed++;
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (RegWrite !== 1'b1 || WriteReg !== 5'(i) || overflow !== 1'b1)
                $display("FAIL ovf_drain%0d: got rw=%0b reg=%0d ovf=%0b want 1/%0d/1",
                         i, RegWrite, WriteReg, overflow, i);
            else passed++;
        end
        tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL ovf_dropped: got %0b want 0", RegWrite); else passed++;
        do_reset();
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", overflow); else passed++;
    endtask

    task automatic test_squash();
        int writes5;
        do_reset();
        writes5 = 0;
        pend_reg = 5'd5;
        mem_valid = 1; mem_reg = 5'd5; mem_data = 32'hBB;
        tick();
        total++; if (pend_hit !== 1'b1) $display("FAIL sq_pend: got %0b want 1", pend_hit); else passed++;
        idle();
        alu_valid = 1; alu_reg = 5'd5; alu_data = 32'hCC;
        tick();
        total++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'hCC)
            $display("FAIL sq_alu: got rw=%0b reg=%0d data=%0h want 1/5/cc", RegWrite, WriteReg, WriteData);
        else passed++;
        if (RegWrite === 1'b1 && WriteReg === 5'd5) writes5++;
        idle();
        tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL sq_killed: got %0b want 0", RegWrite); else passed++;
        if (RegWrite === 1'b1 && WriteReg === 5'd5) writes5++;
        total++; if (pend_hit !== 1'b0) $display("FAIL sq_pend_off: got %0b want 0", pend_hit); else passed++;
        tick();
        if (RegWrite === 1'b1 && WriteReg === 5'd5) writes5++;
        total++; if (writes5 != 1) $display("FAIL sq_count: got %0d want 1", writes5); else passed++;
    endtask

    task automatic test_reg0();
        do_reset();
        pend_reg = 5'd0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_reg = 5'd0; alu_data = $urandom;
            mem_valid = 1; mem_reg = 5'd0; mem_data = $urandom;
            tick();
            total++;
            if (RegWrite !== 1'b0 || pend_hit !== 1'b0 || mem_ready !== 1'b1)
                $display("FAIL reg0_%0d: got rw=%0b hit=%0b rdy=%0b want 0/0/1", i, RegWrite, pend_hit, mem_ready);
            else passed++;
        end
        idle();
        tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL reg0_drain: got %0b want 0", RegWrite); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1; alu_reg = 5'd0;
        for (int i = 1; i <= 3; i++) begin
            mem_valid = 1; mem_reg = 5'(i); mem_data = $urandom;
            tick();
        end
        idle();
        reset = 1;
        tick();
        reset = 0;
        pend_reg = 5'd1;
        tick();
        total++;
        if (RegWrite !== 1'b0 || pend_hit !== 1'b0 || mem_ready !== 1'b1)
            $display("FAIL rst_mid: got rw=%0b hit=%0b rdy=%0b want 0/0/1", RegWrite, pend_hit, mem_ready);
        else passed++;
        tick();
        total++; if (RegWrite !== 1'b0) $display("FAIL rst_mid2: got %0b want 0", RegWrite); else passed++;
    endtask

    task automatic test_bypass();
        logic [31:0] want_new;
        logic [31:0] want_old;
`ifdef WB_BYPASS_EN
        want_new = 32'h2; want_old = 32'h1;
`else
        want_new = 32'h0; want_old = 32'h0;
`endif
        do_reset();
        pend_reg = 5'd7;
        alu_valid = 1; alu_reg = 5'd0;
        mem_valid = 1; mem_reg = 5'd7; mem_data = 32'h1;
        tick();
        total++; if (pend_data !== want_old) $display("FAIL byp_one: got %0h want %0h", pend_data, want_old); else passed++;
        mem_data = 32'h2;
        tick();
        total++;
        if (pend_hit !== 1'b1 || pend_data !== want_new)
            $display("FAIL byp_two: got hit=%0b data=%0h want 1/%0h", pend_hit, pend_data, want_new);
        else passed++;
        idle();
        tick();
        total++; if (pend_data !== want_new) $display("FAIL byp_pop1: got %0h want %0h", pend_data, want_new); else passed++;
        tick();
        total++;
        if (pend_hit !== 1'b1 || pend_data !== want_new)
            $display("FAIL byp_outreg: got hit=%0b data=%0h want 1/%0h", pend_hit, pend_data, want_new);
        else passed++;
        tick();
        total++;
        if (pend_hit !== 1'b0 || pend_data !== 32'h0)
            $display("FAIL byp_gone: got hit=%0b data=%0h want 0/0", pend_hit, pend_data);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset     = $urandom_range(0, 59) == 0;
            alu_valid = $urandom_range(0, 9) < 4;
            alu_reg   = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_valid = $urandom_range(0, 9) < 5;
            mem_reg   = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            pend_reg  = 5'($urandom_range(0, 7));
            tick();
            total++;
            if (RegWrite !== m_rw || (m_rw && (WriteReg !== m_wr || WriteData !== m_wd)))
                $display("FAIL rnd_wb%0d: got %0b/%0d/%0h want %0b/%0d/%0h",
                         n, RegWrite, WriteReg, WriteData, m_rw, m_wr, m_wd);
            else passed++;
            total++;
            if (mem_ready !== (q.size() < DEPTH) || overflow !== m_ovf)
                $display("FAIL rnd_flow%0d: got rdy=%0b ovf=%0b want %0b/%0b",
                         n, mem_ready, overflow, q.size() < DEPTH, m_ovf);
            else passed++;
            total++;
            if (pend_hit !== exp_hit() || pend_data !== exp_pdata())
                $display("FAIL rnd_pend%0d: got %0b/%0h want %0b/%0h",
                         n, pend_hit, pend_data, exp_hit(), exp_pdata());
            else passed++;
        end
        reset = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_order();
        test_overflow();
        test_squash();
        test_reg0();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
